// File: rtl/rect_fall_ctl.sv
// Gravity/bounce controller for the rectangle ypos; position and velocity
// step once per frame at the rising edge of vblnk so the drawn image never tears.
module rect_fall_ctl #(
    parameter int Y_MAX  = 500,
    parameter int Y_INIT = 0,
    parameter int ACCEL  = 1,
    parameter int V_MAX  = 16,
    parameter int DAMP   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        start,
    input  logic [11:0] ypos_init,
    output logic [11:0] ypos,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FALL, RISE} state_t;

    localparam logic [11:0] YMAX_V  = 12'(Y_MAX);
    localparam logic [12:0] YMAX_W  = 13'(Y_MAX);
    localparam logic [11:0] YINIT_V = 12'(Y_INIT);
    localparam logic [5:0]  ACCEL_V = 6'(ACCEL);
    localparam logic [5:0]  VMAX_V  = 6'(V_MAX);

    state_t      state_q, state_d;
    logic [11:0] ypos_q, ypos_d;
    logic [5:0]  vel_q, vel_d;
    logic        vblnk_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        tick;
    logic [6:0]  vsum;
    logic [5:0]  v_fall;
    logic [5:0]  v_bounce;
    logic [12:0] y_fall;
    logic [5:0]  v_rise;

    assign tick = vblnk & ~vblnk_q;

    // Falling step: saturate velocity, then add with a spare bit so the floor test cannot wrap.
    assign vsum     = {1'b0, vel_q} + {1'b0, ACCEL_V};
    assign v_fall   = (vsum > {1'b0, VMAX_V}) ? VMAX_V : vsum[5:0];
    assign v_bounce = v_fall >> DAMP;
    assign y_fall   = {1'b0, ypos_q} + {7'd0, v_fall};
    assign v_rise   = vel_q - ACCEL_V;

    always_comb begin
        state_d = state_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    ypos_d  = (ypos_init > YMAX_V) ? YMAX_V : ypos_init;
                    vel_d   = 6'd0;
                    busy_d  = 1'b1;
                    state_d = FALL;
                end
            end
            FALL: begin
                if (tick) begin
                    if (y_fall < YMAX_W) begin
                        ypos_d = y_fall[11:0];
                        vel_d  = v_fall;
                    end else begin
                        ypos_d = YMAX_V;
                        vel_d  = v_bounce;
                        if (v_bounce == 6'd0) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RISE;
                        end
                    end
                end
            end
            RISE: begin
                if (tick) begin
                    if (vel_q <= ACCEL_V) begin
                        vel_d   = 6'd0;
                        state_d = FALL;
                    end else if (ypos_q < {6'd0, v_rise}) begin
                        // Would cross the top edge: pin to 0 and start falling.
                        ypos_d  = 12'd0;
                        vel_d   = 6'd0;
                        state_d = FALL;
                    end else begin
                        ypos_d = ypos_q - {6'd0, v_rise};
                        vel_d  = v_rise;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ypos_q  <= YINIT_V;
            vel_q   <= 6'd0;
            vblnk_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ypos_q  <= ypos_d;
            vel_q   <= vel_d;
            vblnk_q <= vblnk;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ypos = ypos_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
